// File: rtl/alarm_controller_pkg.sv
// Shared definitions for the alarm stage: FSM encoding, BCD limits and default timing.
package alarm_controller_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_RINGING = 2'd1;
    localparam logic [1:0] ST_SNOOZE  = 2'd2;

    localparam int MAX_HOUR_BCD = 23;
    localparam int MAX_MIN_TENS = 5;
    localparam int MAX_DIGIT    = 9;

    localparam int DEF_RING_TIMEOUT = 60;
    localparam int DEF_SNOOZE_SEC   = 300;
    localparam int DEF_MAX_SNOOZE   = 3;

    typedef struct packed {
        logic [1:0] h1;
        logic [3:0] h0;
        logic [3:0] m1;
        logic [3:0] m0;
    } bcd_hhmm_t;

    function automatic logic digit_ok(input logic [3:0] d);
        return d <= 4'(MAX_DIGIT);
    endfunction

endpackage

// File: rtl/alarm_controller_if.sv
// Panel-side signal bundle of the alarm stage: time digits in, controls in, status out.
interface alarm_controller_if;
    import alarm_controller_pkg::*;

    logic [1:0] T_H1;
    logic [3:0] T_H0;
    logic [3:0] T_M1;
    logic [3:0] T_M0;
    logic [3:0] T_S1;
    logic [3:0] T_S0;

    logic [1:0] AL_H1;
    logic [3:0] AL_H0;
    logic [3:0] AL_M1;
    logic [3:0] AL_M0;
    logic       LD_alarm;
    logic       alarm_en;
    logic       snooze;
    logic       stop;

    logic       buzzer;
    logic       ringing;
    logic       snoozing;
    logic       missed;
    logic       load_err;
    logic [1:0] snooze_left;
    logic [1:0] alm_H1;
    logic [3:0] alm_H0;
    logic [3:0] alm_M1;
    logic [3:0] alm_M0;

    modport master (
        output T_H1, T_H0, T_M1, T_M0, T_S1, T_S0,
        output AL_H1, AL_H0, AL_M1, AL_M0, LD_alarm, alarm_en, snooze, stop,
        input  buzzer, ringing, snoozing, missed, load_err, snooze_left,
        input  alm_H1, alm_H0, alm_M1, alm_M0
    );

    modport slave (
        input  T_H1, T_H0, T_M1, T_M0, T_S1, T_S0,
        input  AL_H1, AL_H0, AL_M1, AL_M0, LD_alarm, alarm_en, snooze, stop,
        output buzzer, ringing, snoozing, missed, load_err, snooze_left,
        output alm_H1, alm_H0, alm_M1, alm_M0
    );

endinterface

// File: rtl/alarm_controller_validate.sv
// Combinational BCD hh:mm range check; shared with future time-set logic.
module alarm_time_validate
    import alarm_controller_pkg::*;
(
    input  bcd_hhmm_t t,
    output logic      valid
);

    localparam logic [1:0] HOUR_TENS_MAX  = 2'(MAX_HOUR_BCD / 10);
    localparam logic [3:0] HOUR_UNITS_MAX = 4'(MAX_HOUR_BCD % 10);
    localparam logic [3:0] MIN_TENS_MAX   = 4'(MAX_MIN_TENS);

    logic hour_ok;
    logic min_ok;

    // Hour range is judged digit-wise so 2x only admits units up to 3.
    always_comb begin
        hour_ok = digit_ok(t.h0) &&
                  ((t.h1 < HOUR_TENS_MAX) ||
                   ((t.h1 == HOUR_TENS_MAX) && (t.h0 <= HOUR_UNITS_MAX)));
        min_ok  = (t.m1 <= MIN_TENS_MAX) && digit_ok(t.m0);
        valid   = hour_ok && min_ok;
    end

endmodule

// File: rtl/alarm_controller.sv
// Alarm stage: stores the alarm time and runs the ring/snooze FSM on clk_1s.
//   state       | meaning
//   ST_IDLE     | armed (if alarm_en), waiting for hh:mm:00 match
//   ST_RINGING  | buzzer toggling, ring_cnt counting toward timeout
//   ST_SNOOZE   | silent, snz_cnt counting down to re-ring
module alarm_controller
    import alarm_controller_pkg::*;
#(
    parameter int RING_TIMEOUT = DEF_RING_TIMEOUT,
    parameter int SNOOZE_SEC   = DEF_SNOOZE_SEC,
    parameter int MAX_SNOOZE   = DEF_MAX_SNOOZE
) (
    input  logic               clk_1s,
    input  logic               reset,
    alarm_controller_if.slave  bus
);

    localparam int RW = $clog2(RING_TIMEOUT);
    localparam int SW = $clog2(SNOOZE_SEC);
    localparam logic [RW-1:0] RING_LAST = RW'(RING_TIMEOUT - 1);
    localparam logic [SW-1:0] SNZ_LOAD  = SW'(SNOOZE_SEC - 1);
    localparam logic [1:0]    SNZ_MAX   = 2'(MAX_SNOOZE);

    logic [1:0]    state;
    logic [RW-1:0] ring_cnt;
    logic [SW-1:0] snz_cnt;
    bcd_hhmm_t     alm;
    bcd_hhmm_t     al_in;
    logic          al_valid;
    logic          time_match;
    logic          buzzer_q;
    logic          missed_q;
    logic          load_err_q;
    logic [1:0]    snooze_left_q;

    assign al_in = {bus.AL_H1, bus.AL_H0, bus.AL_M1, bus.AL_M0};

    alarm_time_validate u_validate (
        .t     (al_in),
        .valid (al_valid)
    );

    assign time_match = (bus.T_H1 == alm.h1) && (bus.T_H0 == alm.h0) &&
                        (bus.T_M1 == alm.m1) && (bus.T_M0 == alm.m0) &&
                        (bus.T_S1 == 4'd0)   && (bus.T_S0 == 4'd0);

    always_ff @(posedge clk_1s or posedge reset) begin
        if (reset) begin
            state         <= ST_IDLE;
            ring_cnt      <= '0;
            snz_cnt       <= '0;
            alm           <= '0;
            buzzer_q      <= 1'b0;
            missed_q      <= 1'b0;
            load_err_q    <= 1'b0;
            snooze_left_q <= SNZ_MAX;
        end else if (bus.LD_alarm) begin
            // An invalid load keeps the previous alarm time but still disarms the event.
            if (al_valid) begin
                alm        <= al_in;
                load_err_q <= 1'b0;
            end else begin
                load_err_q <= 1'b1;
            end
            state         <= ST_IDLE;
            buzzer_q      <= 1'b0;
            missed_q      <= 1'b0;
            snooze_left_q <= SNZ_MAX;
        end else if (!bus.alarm_en || bus.stop) begin
            state    <= ST_IDLE;
            buzzer_q <= 1'b0;
            if (bus.stop) begin
                missed_q <= 1'b0;
            end
        end else begin
            case (state)
                ST_IDLE: begin
                    if (time_match) begin
                        state         <= ST_RINGING;
                        buzzer_q      <= 1'b1;
                        ring_cnt      <= '0;
                        snooze_left_q <= SNZ_MAX;
                    end
                end
                ST_RINGING: begin
                    ring_cnt <= ring_cnt + 1'b1;
                    buzzer_q <= ~buzzer_q;
                    if (bus.snooze && (snooze_left_q != 2'd0)) begin
                        state         <= ST_SNOOZE;
                        buzzer_q      <= 1'b0;
                        snooze_left_q <= snooze_left_q - 1'b1;
                        snz_cnt       <= SNZ_LOAD;
                    end else if (ring_cnt == RING_LAST) begin
                        state    <= ST_IDLE;
                        buzzer_q <= 1'b0;
                        missed_q <= 1'b1;
                    end
                end
                ST_SNOOZE: begin
                    if (snz_cnt == '0) begin
                        state    <= ST_RINGING;
                        buzzer_q <= 1'b1;
                        ring_cnt <= '0;
                    end else begin
                        snz_cnt <= snz_cnt - 1'b1;
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    buzzer_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.buzzer      = buzzer_q;
    assign bus.ringing     = (state == ST_RINGING);
    assign bus.snoozing    = (state == ST_SNOOZE);
    assign bus.missed      = missed_q;
    assign bus.load_err    = load_err_q;
    assign bus.snooze_left = snooze_left_q;
    assign bus.alm_H1      = alm.h1;
    assign bus.alm_H0      = alm.h0;
    assign bus.alm_M1      = alm.m1;
    assign bus.alm_M0      = alm.m0;

endmodule

// File: tb/tb_alarm_controller.sv
// Directed scoreboard bench for alarm_controller: driver queues expected status,
// monitor compares after each clk_1s edge or an explicit async-reset probe.
module tb_alarm_controller;

    logic clk_1s = 1'b0;
    logic reset;

    always #5 clk_1s = ~clk_1s;

    alarm_controller_if bus ();

    alarm_controller dut (
        .clk_1s (clk_1s),
        .reset  (reset),
        .bus    (bus)
    );

    typedef struct {
        string       name;
        logic [20:0] v;
    } exp_t;

    exp_t sb_q[$];
    event chk_ev;
    int   checks = 0;
    int   errors = 0;

    logic        e_buz, e_ring, e_snz, e_miss, e_lerr;
    logic [1:0]  e_left;
    logic [13:0] e_alm;

    function automatic string fmt(input logic [20:0] v);
        return $sformatf("buz=%b ring=%b snz=%b miss=%b lerr=%b left=%0d alm=%h",
                         v[20], v[19], v[18], v[17], v[16], v[15:14], v[13:0]);
    endfunction

    task automatic push(input string nm);
        exp_t e;
        e.name = nm;
        e.v    = {e_buz, e_ring, e_snz, e_miss, e_lerr, e_left, e_alm};
        sb_q.push_back(e);
    endtask

    // Monitor: pops whatever the driver queued for this edge / probe.
    initial begin
        exp_t        cur;
        logic [20:0] got;
        forever begin
            @(posedge clk_1s or chk_ev);
            #1;
            while (sb_q.size() > 0) begin
                cur = sb_q.pop_front();
                got = {bus.buzzer, bus.ringing, bus.snoozing, bus.missed, bus.load_err,
                       bus.snooze_left, bus.alm_H1, bus.alm_H0, bus.alm_M1, bus.alm_M0};
                checks++;
                if (got !== cur.v) begin
                    errors++;
                    $display("FAIL %s: got %s, expected %s", cur.name, fmt(got), fmt(cur.v));
                end
            end
        end
    end

    task automatic set_time(input logic [1:0] h1, input logic [3:0] h0, input logic [3:0] m1,
                            input logic [3:0] m0, input logic [3:0] s1, input logic [3:0] s0);
        bus.T_H1 = h1; bus.T_H0 = h0; bus.T_M1 = m1;
        bus.T_M0 = m0; bus.T_S1 = s1; bus.T_S0 = s0;
    endtask

    task automatic set_al(input logic [1:0] h1, input logic [3:0] h0,
                          input logic [3:0] m1, input logic [3:0] m0);
        bus.AL_H1 = h1; bus.AL_H0 = h0; bus.AL_M1 = m1; bus.AL_M0 = m0;
    endtask

    task automatic tick_chk(input string nm);
        push(nm);
        @(posedge clk_1s);
        @(negedge clk_1s);
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            @(posedge clk_1s);
            @(negedge clk_1s);
        end
    endtask

    task automatic expect_reset_vals();
        e_buz = 1'b0; e_ring = 1'b0; e_snz = 1'b0; e_miss = 1'b0; e_lerr = 1'b0;
        e_left = 2'd3; e_alm = 14'h0000;
    endtask

    initial begin
        reset = 1'b1;
        set_time(2'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0);
        set_al(2'd0, 4'd0, 4'd0, 4'd0);
        bus.LD_alarm = 1'b0;
        bus.alarm_en = 1'b0;
        bus.snooze   = 1'b0;
        bus.stop     = 1'b0;
        expect_reset_vals();
        #3;
        push("reset_state");
        ->chk_ev;
        #2;
        @(negedge clk_1s);
        reset = 1'b0;

        // Load 07:30 and trigger on the :00 second.
        set_al(2'd0, 4'd7, 4'd3, 4'd0);
        bus.LD_alarm = 1'b1;
        bus.alarm_en = 1'b1;
        set_time(2'd0, 4'd7, 4'd2, 4'd9, 4'd5, 4'd8);
        e_alm = 14'h0730;
        tick_chk("load_0730");
        bus.LD_alarm = 1'b0;
        set_time(2'd0, 4'd7, 4'd2, 4'd9, 4'd5, 4'd9);
        tick_chk("no_ring_early");
        set_time(2'd0, 4'd7, 4'd3, 4'd0, 4'd0, 4'd0);
        e_ring = 1'b1; e_buz = 1'b1;
        tick_chk("trigger");
        set_time(2'd0, 4'd7, 4'd3, 4'd0, 4'd0, 4'd1);
        e_buz = 1'b0; tick_chk("buz_e1");
        e_buz = 1'b1; tick_chk("buz_e2");
        e_buz = 1'b0; tick_chk("buz_e3");

        // Unattended: timeout on the 60th edge after trigger.
        ticks(55);
        e_buz = 1'b0; tick_chk("ring_e59");
        e_ring = 1'b0; e_miss = 1'b1;
        tick_chk("timeout_missed");
        tick_chk("missed_sticky");
        bus.stop = 1'b1;
        e_miss = 1'b0;
        tick_chk("stop_clears_missed");
        bus.stop = 1'b0;

        // Three snoozes, then a fourth that must be ignored.
        set_time(2'd0, 4'd7, 4'd3, 4'd0, 4'd0, 4'd0);
        e_ring = 1'b1; e_buz = 1'b1; e_left = 2'd3;
        tick_chk("retrigger");
        set_time(2'd0, 4'd7, 4'd3, 4'd0, 4'd0, 4'd1);
        for (int r = 0; r < 3; r++) begin
            bus.snooze = 1'b1;
            e_ring = 1'b0; e_snz = 1'b1; e_buz = 1'b0; e_left = 2'(2 - r);
            tick_chk("snooze_enter");
            ticks(298);
            tick_chk("snooze_hold");
            bus.snooze = 1'b0;
            e_ring = 1'b1; e_snz = 1'b0; e_buz = 1'b1;
            tick_chk("snooze_wake");
        end
        bus.snooze = 1'b1;
        e_buz = 1'b0; e_left = 2'd0;
        tick_chk("snooze_exhausted");

        // stop wins over snooze.
        bus.stop = 1'b1;
        e_ring = 1'b0; e_buz = 1'b0;
        tick_chk("stop_idle_left0");
        bus.stop = 1'b0;
        bus.snooze = 1'b0;
        set_time(2'd0, 4'd7, 4'd3, 4'd0, 4'd0, 4'd0);
        e_ring = 1'b1; e_buz = 1'b1; e_left = 2'd3;
        tick_chk("retrigger2");
        set_time(2'd0, 4'd7, 4'd3, 4'd0, 4'd0, 4'd1);
        bus.stop = 1'b1;
        bus.snooze = 1'b1;
        e_ring = 1'b0; e_buz = 1'b0;
        tick_chk("stop_beats_snooze");
        bus.stop = 1'b0;
        bus.snooze = 1'b0;

        // Invalid loads keep 07:30, then 23:59 is accepted and triggers.
        bus.LD_alarm = 1'b1;
        set_al(2'd2, 4'd4, 4'd0, 4'd0);
        e_lerr = 1'b1;
        tick_chk("load_24_00");
        set_al(2'd1, 4'd2, 4'd6, 4'd0);
        tick_chk("load_12_60");
        set_al(2'd2, 4'd3, 4'd5, 4'd9);
        e_lerr = 1'b0; e_alm = 14'h2359;
        tick_chk("load_23_59");
        bus.LD_alarm = 1'b0;
        set_time(2'd2, 4'd3, 4'd5, 4'd8, 4'd5, 4'd9);
        tick_chk("no_ring_2358");
        set_time(2'd2, 4'd3, 4'd5, 4'd9, 4'd0, 4'd0);
        e_ring = 1'b1; e_buz = 1'b1;
        tick_chk("trigger_2359");

        // Async reset in the middle of a snooze.
        set_time(2'd2, 4'd3, 4'd5, 4'd9, 4'd0, 4'd1);
        bus.snooze = 1'b1;
        e_ring = 1'b0; e_snz = 1'b1; e_buz = 1'b0; e_left = 2'd2;
        tick_chk("snooze_before_reset");
        bus.snooze = 1'b0;
        ticks(5);
        #2;
        reset = 1'b1;
        #1;
        expect_reset_vals();
        push("reset_mid_snooze");
        ->chk_ev;
        #2;
        @(negedge clk_1s);
        reset = 1'b0;

        // alarm_en gates triggering at the reset alarm time 00:00.
        bus.alarm_en = 1'b0;
        set_time(2'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0);
        tick_chk("en0_no_ring");
        bus.alarm_en = 1'b1;
        e_ring = 1'b1; e_buz = 1'b1;
        tick_chk("en1_ring_0000");
        bus.alarm_en = 1'b0;
        e_ring = 1'b0; e_buz = 1'b0;
        tick_chk("en0_forces_idle");

        ticks(2);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
